// File: rtl/updown_counter_7seg_mux.sv
// Multi-digit BCD/hex up/down counter with a tick prescaler and a time-multiplexed
// 7-segment driver. Per-digit step/clamp/zero-detect lives in updown_digit.
module updown_digit #(
  parameter int RADIX = 10
) (
  input  logic [3:0] d,
  input  logic [3:0] ld,
  input  logic       dir,
  input  logic       cin,
  input  logic       uz_in,
  output logic [3:0] nxt,
  output logic [3:0] ld_clamp,
  output logic       cout,
  output logic       uz_out
);
  localparam logic [3:0] MAXD = 4'(RADIX - 1);

  always_comb begin
    nxt  = d;
    cout = 1'b0;
    if (cin) begin
      if (dir) begin
        if (d == MAXD) begin nxt = 4'd0; cout = 1'b1; end
        else nxt = d + 4'd1;
      end else begin
        if (d == 4'd0) begin nxt = MAXD; cout = 1'b1; end
        else nxt = d - 4'd1;
      end
    end
  end

  assign ld_clamp = (ld > MAXD) ? MAXD : ld;
  // true when this digit and every digit above it are zero
  assign uz_out   = uz_in & (d == 4'd0);
endmodule

module updown_counter_7seg_mux #(
  parameter int DIGITS         = 4,
  parameter int RADIX          = 10,
  parameter int DIV_COUNT      = 50000000,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1,
  parameter bit AN_ACTIVE_LOW  = 1,
  parameter bit BLANK_LEADING  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dir,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   value,
  output logic                  wrap,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);
  localparam int PW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACTIVE_LOW}};

  function automatic logic [6:0] seg_lut(input logic [3:0] h);
    case (h)
      4'h0: seg_lut = 7'h3F; 4'h1: seg_lut = 7'h06; 4'h2: seg_lut = 7'h5B; 4'h3: seg_lut = 7'h4F;
      4'h4: seg_lut = 7'h66; 4'h5: seg_lut = 7'h6D; 4'h6: seg_lut = 7'h7D; 4'h7: seg_lut = 7'h07;
      4'h8: seg_lut = 7'h7F; 4'h9: seg_lut = 7'h6F; 4'hA: seg_lut = 7'h77; 4'hB: seg_lut = 7'h7C;
      4'hC: seg_lut = 7'h39; 4'hD: seg_lut = 7'h5E; 4'hE: seg_lut = 7'h79; default: seg_lut = 7'h71;
    endcase
  endfunction

  logic [DIGITS-1:0][3:0] dig, dig_nx, dig_ld;
  logic [DIGITS:0]        carry, uz;
  logic [DIGITS-1:0]      blank_d;
  logic [PW-1:0]          presc;
  logic [SW-1:0]          scnt;
  logic [IW-1:0]          idx;
  logic                   tick, step, scan_step;
  logic [6:0]             pat, seg_nx;
  logic [DIGITS-1:0]      an_nx;

  assign carry[0]   = 1'b1;
  assign uz[DIGITS] = 1'b1;
  assign blank_d    = uz[DIGITS-1:0];

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    updown_digit #(.RADIX(RADIX)) u_dig (
      .d(dig[i]), .ld(load_val[4*i +: 4]), .dir(dir), .cin(carry[i]), .uz_in(uz[i+1]),
      .nxt(dig_nx[i]), .ld_clamp(dig_ld[i]), .cout(carry[i+1]), .uz_out(uz[i])
    );
  end

  assign tick      = (presc == PW'(DIV_COUNT - 1));
  assign step      = tick & en & ~load;
  assign scan_step = (scnt == SW'(SCAN_DIV - 1));
  assign value     = dig;

  always_comb begin
    pat = seg_lut(dig[idx]);
    if (BLANK_LEADING && (idx != '0) && blank_d[idx]) pat = 7'h00;
    seg_nx = SEG_ACTIVE_LOW ? ~pat : pat;
    an_nx  = DIGITS'(1) << idx;
    if (AN_ACTIVE_LOW) an_nx = ~an_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      scnt  <= '0;
      idx   <= '0;
      dig   <= '0;
      wrap  <= 1'b0;
      seg   <= SEG_OFF;
      an    <= AN_OFF;
    end else begin
      // load restarts the tick period so the first step lands DIV_COUNT cycles later
      presc <= (load || tick) ? '0 : presc + 1'b1;
      if (load) dig <= dig_ld;
      else if (step) dig <= dig_nx;
      wrap <= step & carry[DIGITS];
      if (scan_step) begin
        scnt <= '0;
        idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        scnt <= scnt + 1'b1;
      end
      seg <= seg_nx;
      an  <= an_nx;
    end
  end
endmodule

// File: tb/tb_updown_counter_7seg_mux.sv
// Bench for updown_counter_7seg_mux: a BCD active-low blanking instance and a hex
// active-high instance, checked each cycle against a numeric reference model.
module tb_updown_counter_7seg_mux;
  logic clk = 1'b0, rst, dir, en, load;
  logic [15:0] load_val;
  logic [15:0] v0; logic w0; logic [6:0] s0; logic [3:0] a0;
  logic [7:0]  v1; logic w1; logic [6:0] s1; logic [1:0] a1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  updown_counter_7seg_mux #(.DIGITS(4), .RADIX(10), .DIV_COUNT(4), .SCAN_DIV(2),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)) u_bcd (
    .clk(clk), .rst(rst), .dir(dir), .en(en), .load(load), .load_val(load_val),
    .value(v0), .wrap(w0), .seg(s0), .an(a0));

  updown_counter_7seg_mux #(.DIGITS(2), .RADIX(16), .DIV_COUNT(3), .SCAN_DIV(3),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0), .BLANK_LEADING(0)) u_hex (
    .clk(clk), .rst(rst), .dir(dir), .en(en), .load(load), .load_val(load_val[7:0]),
    .value(v1), .wrap(w1), .seg(s1), .an(a1));

  localparam int CD[2]  = '{4, 2};
  localparam int CR[2]  = '{10, 16};
  localparam int CDV[2] = '{4, 3};
  localparam int CSC[2] = '{2, 3};
  localparam bit CSL[2] = '{1'b1, 1'b0};
  localparam bit CAL[2] = '{1'b1, 1'b0};
  localparam bit CBL[2] = '{1'b1, 1'b0};
  localparam logic [6:0] SEGT[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    int n, pc, sc, idx;
    logic wrap;
    logic [6:0] seg;
    logic [7:0] an;
  } mst_t;

  mst_t ms[2];
  bit   mvalid = 1'b0;

  function automatic int pw(int b, int e);
    int r = 1;
    for (int i = 0; i < e; i++) r *= b;
    return r;
  endfunction

  // model state is the count as a plain integer; digits are derived by division
  function automatic mst_t mstep(mst_t s, int k, logic r, logic d, logic e, logic l, logic [15:0] lv);
    mst_t o = s;
    int D = CD[k], R = CR[k], mx, dg, c;
    logic [6:0] p;
    logic [7:0] a;
    mx = pw(R, D) - 1;
    if (r) begin
      o.n = 0; o.pc = 0; o.sc = 0; o.idx = 0; o.wrap = 1'b0;
      o.seg = CSL[k] ? 7'h7F : 7'h00;
      o.an  = CAL[k] ? 8'((1 << D) - 1) : 8'h00;
      return o;
    end
    dg = (s.n / pw(R, s.idx)) % R;
    p = SEGT[dg];
    if (CBL[k] && s.idx > 0 && s.n < pw(R, s.idx)) p = 7'h00;
    o.seg = CSL[k] ? ~p : p;
    a = 8'(1 << s.idx);
    if (CAL[k]) a = ~a & 8'((1 << D) - 1);
    o.an = a;
    if (s.sc == CSC[k] - 1) begin o.sc = 0; o.idx = (s.idx + 1) % D; end
    else o.sc = s.sc + 1;
    o.pc = (s.pc == CDV[k] - 1) ? 0 : s.pc + 1;
    o.wrap = 1'b0;
    if (l) begin
      o.n = 0;
      for (int i = 0; i < D; i++) begin
        c = int'(lv[4*i +: 4]);
        if (c > R - 1) c = R - 1;
        o.n += c * pw(R, i);
      end
      o.pc = 0;
    end else if (s.pc == CDV[k] - 1 && e) begin
      if (d) begin
        if (s.n == mx) begin o.n = 0; o.wrap = 1'b1; end
        else o.n = s.n + 1;
      end else begin
        if (s.n == 0) begin o.n = mx; o.wrap = 1'b1; end
        else o.n = s.n - 1;
      end
    end
    return o;
  endfunction

  function automatic logic [15:0] exp_val(int n, int k);
    logic [15:0] r = '0;
    for (int i = 0; i < CD[k]; i++) r[4*i +: 4] = 4'((n / pw(CR[k], i)) % CR[k]);
    return r;
  endfunction

  always @(posedge clk) begin
    ms[0]  <= mstep(ms[0], 0, rst, dir, en, load, load_val);
    ms[1]  <= mstep(ms[1], 1, rst, dir, en, load, load_val);
    mvalid <= mvalid | rst;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_value0", v0, exp_val(ms[0].n, 0));
      chk("m_wrap0",  w0, ms[0].wrap);
      chk("m_seg0",   s0, ms[0].seg);
      chk("m_an0",    a0, ms[0].an[3:0]);
      chk("m_value1", v1, exp_val(ms[1].n, 1));
      chk("m_wrap1",  w1, ms[1].wrap);
      chk("m_seg1",   s1, ms[1].seg);
      chk("m_an1",    a1, ms[1].an[1:0]);
    end
  end

  typedef struct {
    logic [15:0] lv;
    logic        d;
    logic [15:0] after_load;
    logic [15:0] after_tick;
    logic        w;
  } vec_t;

  vec_t vt[8];

  task automatic chk_reset();
    chk("rst_value", v0, 16'h0000);
    chk("rst_wrap",  w0, 1'b0);
    chk("rst_an",    a0, 4'hF);
    chk("rst_seg",   s0, 7'h7F);
    chk("rst_an_h",  a1, 2'b00);
    chk("rst_seg_h", s1, 7'h00);
  endtask

  initial begin
    logic [3:0] prev;
    bit found;
    vt[0] = '{16'h0009, 1'b1, 16'h0009, 16'h0010, 1'b0};
    vt[1] = '{16'h9999, 1'b1, 16'h9999, 16'h0000, 1'b1};
    vt[2] = '{16'h0000, 1'b0, 16'h0000, 16'h9999, 1'b1};
    vt[3] = '{16'h0010, 1'b0, 16'h0010, 16'h0009, 1'b0};
    vt[4] = '{16'h00AF, 1'b1, 16'h0099, 16'h0100, 1'b0};
    vt[5] = '{16'h5FFF, 1'b0, 16'h5999, 16'h5998, 1'b0};
    vt[6] = '{16'h1234, 1'b0, 16'h1234, 16'h1233, 1'b0};
    vt[7] = '{16'h0999, 1'b1, 16'h0999, 16'h1000, 1'b0};

    rst = 1'b1; dir = 1'b1; en = 1'b1; load = 1'b0; load_val = '0;
    repeat (3) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("first_an", a0, 4'hE);
    chk("first_seg", s0, 7'h40);
    chk("first_val", v0, 16'h0000);
    repeat (2) @(negedge clk);
    chk("pre_tick", v0, 16'h0000);
    @(negedge clk);
    chk("first_tick", v0, 16'h0001);

    foreach (vt[i]) begin
      load = 1'b1; load_val = vt[i].lv; dir = vt[i].d;
      @(negedge clk);
      load = 1'b0;
      chk("vec_load", v0, vt[i].after_load);
      chk("vec_load_wrap", w0, 1'b0);
      repeat (3) @(negedge clk);
      chk("vec_hold", v0, vt[i].after_load);
      @(negedge clk);
      chk("vec_tick", v0, vt[i].after_tick);
      chk("vec_wrap", w0, vt[i].w);
      @(negedge clk);
      chk("vec_wrap_end", w0, 1'b0);
    end

    // load coinciding with a tick wins and the tick is dropped
    dir = 1'b1;
    load = 1'b1; load_val = 16'h0050;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    load = 1'b1; load_val = 16'h005F;
    @(negedge clk);
    load = 1'b0;
    chk("ldtick_val", v0, 16'h0059);
    chk("ldtick_wrap", w0, 1'b0);
    repeat (3) @(negedge clk);
    chk("ldtick_hold", v0, 16'h0059);
    @(negedge clk);
    chk("ldtick_next", v0, 16'h0060);

    en = 1'b0;
    repeat (12) @(negedge clk);
    chk("en_frozen", v0, 16'h0060);
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_hold", v0, 16'h0060);
    @(negedge clk);
    chk("en_resume", v0, 16'h0061);

    // scan pattern with leading-zero blanking
    en = 1'b0; load = 1'b1; load_val = 16'h0007;
    @(negedge clk);
    load = 1'b0;
    found = 1'b0;
    prev = a0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge clk);
      if (a0 == 4'hE && prev != 4'hE) found = 1'b1;
      else prev = a0;
    end
    chk("scan_found", 16'(found), 16'h1);
    chk("scan_d0_seg", s0, 7'h78);
    @(negedge clk); chk("scan_d0_an2", a0, 4'hE);
    @(negedge clk); chk("scan_d1_an", a0, 4'hD); chk("scan_d1_seg", s0, 7'h7F);
    repeat (2) @(negedge clk); chk("scan_d2_an", a0, 4'hB); chk("scan_d2_seg", s0, 7'h7F);
    repeat (2) @(negedge clk); chk("scan_d3_an", a0, 4'h7); chk("scan_d3_seg", s0, 7'h7F);
    repeat (2) @(negedge clk); chk("scan_wrap_an", a0, 4'hE); chk("scan_wrap_seg", s0, 7'h78);

    // reset mid-count, then count down from zero
    en = 1'b1; dir = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_restart_hold", v0, 16'h0000);
    @(negedge clk);
    chk("rst_down_wrap_val", v0, 16'h9999);
    chk("rst_down_wrap", w0, 1'b1);
    repeat (4) @(negedge clk);
    chk("rst_down_next", v0, 16'h9998);

    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      load     = ($urandom_range(0, 15) == 0);
      en       = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      load_val = 16'($urandom);
      if ($urandom_range(0, 3) == 0) load_val = (dir) ? 16'h9998 : 16'h0001;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/updown_counter_7seg_mux.md
Name: updown_counter_7seg_mux

Overview:
Parametrised multi-digit up/down counter with an integrated prescaler and a time-multiplexed 7-segment driver. It replaces the single-digit divider, counter and decoder chain. It sits at FPGA top level: board clock in, segment and digit-enable lines out to the display. It adds radix select (BCD or hex), enable, synchronous load, wrap flag, leading-zero blanking and selectable output polarity.

Parameters:
DIGITS, 4, number of display digits / counter digits (1..8)
RADIX, 10, per-digit modulus; only 10 or 16 are legal
DIV_COUNT, 50000000, clk cycles per count tick (>=2)
SCAN_DIV, 50000, clk cycles per digit-scan step (>=2)
SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (common-anode board)
AN_ACTIVE_LOW, 1, 1 = digit-enable outputs inverted
BLANK_LEADING, 0, 1 = blank leading zero digits

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
dir  in  1  1 = count up, 0 = count down; sampled on tick
en  in  1  count enable; sampled on tick
load  in  1  synchronous load strobe
load_val  in  4*DIGITS  load value, digit i at [4i+3:4i]
value  out  4*DIGITS  current count, digit i at [4i+3:4i]
wrap  out  1  one-cycle pulse on full-range wrap
seg  out  7  segments, seg[0]=a ... seg[6]=g
an  out  DIGITS  digit enables, one-hot when active

Behaviour:
- Reset (rst=1 at edge, overrides everything): prescaler=0, scan counter=0, scan index=0, value=0, wrap=0, seg all off, an all inactive (off/inactive levels honour the polarity parameters).
- Prescaler: counts 0..DIV_COUNT-1, then wraps. Internal tick is high for the one cycle where prescaler==DIV_COUNT-1.
- Load: load=1 sets value<=load_val on the next edge. Any digit >= RADIX is clamped to RADIX-1. Load also clears the prescaler. Load has priority over a coincident tick; that tick is discarded and wrap stays 0.
- Count: on tick with en=1 and load=0, value updates on the same edge.
- Up count: digit 0 increments; a digit at RADIX-1 becomes 0 and carries into the next digit.
- Down count: a digit at 0 becomes RADIX-1 and borrows from the next digit.
- Full wrap: all digits at max going up gives all 0. All 0 going down gives all max. Either case asserts wrap for exactly the cycle after the wrap edge.
- en=0 on tick: value holds and the prescaler keeps running.
- A dir change between ticks takes effect on the next tick only.
- Scan: the scan counter runs 0..SCAN_DIV-1 independently of en and load. At SCAN_DIV-1 the index advances (DIGITS-1 wraps to 0).
- seg and an are registered, giving 1-cycle latency from index/value to pins.
- On the first cycle after rst falls, an selects digit 0 and seg shows digit 0.
- Active-high segment patterns (g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- With SEG_ACTIVE_LOW=1, seg is the bitwise inverse. With AN_ACTIVE_LOW=1, an is the bitwise inverse.
- Blanking (BLANK_LEADING=1): a digit at an index above the most significant nonzero digit shows all segments off, with an still asserted. Digit 0 is never blanked.
- RADIX=10 and hex codes: clamping makes values >9 unreachable, so codes A-F never display.

Test Plan:
1. DIGITS=2, RADIX=10, DIV_COUNT=4, dir=1, en=1, start from reset -> value steps 00,01..99 every 4 clk; 99->00 with one-cycle wrap=1; 09->10 carries.
2. Same config, dir=0 after reset -> first tick gives value=99 with wrap pulse; then 98; 10->09 borrows correctly.
3. load_val=0x5F asserted on a tick cycle -> value=0x59 (digit clamped to 9); no increment that tick; wrap=0; next tick at +4 clk gives 0x60.
4. en=0 for 3 ticks, then en=1 -> value frozen during en=0; count resumes at the next tick with no skipped steps.
5. DIGITS=4, SCAN_DIV=2, value=0x0007, BLANK_LEADING=1, both polarities active-low -> an cycles E,D,B,7 every 2 clk; seg=0x78 on digit 0 and 0x7F on digits 1-3.
6. rst=1 mid-count and mid-scan -> next edge: value=0, wrap=0, an=all 1, seg=all 1 (off); after release, counting restarts from 0 after DIV_COUNT cycles.
